// File: rtl/fios_res_collector.sv
// Purpose : collects the FIOS multiplier's word-serial RES stream (LS word first) and applies
//           the final Montgomery conditional subtraction word-serially as the words arrive.
// Latency : first word sampled LATENCY cycles after start_i; valid_o rises the cycle after the last word.
// Backpres: result_o/valid_o held in HOLD until ready_i; start_i outside IDLE is dropped and pulses err_o.
// Ports   : clock_i/reset_i (sync, active-high), start_i, res_i[16:0], p_i[s*17-1:0], ready_i,
//           result_o[s*17-1:0], valid_o, busy_o (state != IDLE), err_o (ignored-start pulse).
module fios_res_collector #(
    parameter int s          = 8,
    parameter int LATENCY    = 4,
    parameter int RES_STRIDE = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [16:0]       res_i,
    input  logic [s*17-1:0]   p_i,
    input  logic              ready_i,
    output logic [s*17-1:0]   result_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int W     = s * 17;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STR_W = (RES_STRIDE > 1) ? $clog2(RES_STRIDE) : 1;
    localparam int WC_W  = (s > 1) ? $clog2(s) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(s - 1);

    typedef enum logic [1:0] {IDLE, WAIT, COLLECT, HOLD} state_t;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [STR_W-1:0]  str_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              borrow;
    logic [W-1:0]      raw_buf;
    logic [W-1:0]      diff_buf;

    // Current word's subtraction and the buffers as they will look once it is written.
    logic [16:0]  p_word;
    logic [17:0]  sub;
    logic         borrow_out;
    logic [W-1:0] raw_nxt;
    logic [W-1:0] diff_nxt;

    always_comb begin
        p_word   = p_i[int'(word_cnt)*17 +: 17];
        // Extra MSB catches the borrow: the magnitude never exceeds 2^17, so bit 17 set means negative.
        sub      = {1'b0, res_i} - {1'b0, p_word} - {17'b0, borrow};
        borrow_out = sub[17];
        raw_nxt  = raw_buf;
        diff_nxt = diff_buf;
        raw_nxt[int'(word_cnt)*17 +: 17]  = res_i;
        diff_nxt[int'(word_cnt)*17 +: 17] = sub[16:0];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            str_cnt  <= '0;
            word_cnt <= '0;
            borrow   <= 1'b0;
            raw_buf  <= '0;
            diff_buf <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        word_cnt <= '0;
                        str_cnt  <= '0;
                        borrow   <= 1'b0;
                        busy_o   <= 1'b1;
                        lat_cnt  <= LAT_W'(LATENCY - 1);
                        // With LATENCY=1 the first word arrives the very next cycle.
                        state    <= (LATENCY == 1) ? COLLECT : WAIT;
                    end
                end
                WAIT: begin
                    if (start_i) err_o <= 1'b1;
                    lat_cnt <= lat_cnt - 1'b1;
                    // Leave one cycle early so COLLECT is active on cycle LATENCY itself.
                    if (lat_cnt == LAT_W'(1)) state <= COLLECT;
                end
                COLLECT: begin
                    if (start_i) err_o <= 1'b1;
                    if (str_cnt == '0) begin
                        raw_buf  <= raw_nxt;
                        diff_buf <= diff_nxt;
                        borrow   <= borrow_out;
                        str_cnt  <= STR_W'(RES_STRIDE - 1);
                        if (word_cnt == LAST_WORD) begin
                            // Final borrow clear means result >= p, so the difference is the answer.
                            result_o <= borrow_out ? raw_nxt : diff_nxt;
                            valid_o  <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        str_cnt <= str_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (start_i) err_o <= 1'b1;
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fios_res_collector.sv
// Purpose : directed table vectors plus corner sequences for fios_res_collector (s=2).
// Latency : dut uses LATENCY=3/RES_STRIDE=1, dut2 uses LATENCY=3/RES_STRIDE=2.
// Backpres: ready_i is held low for per-vector cycle counts to exercise HOLD.
module tb_fios_res_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [16:0] res, res2;
    logic [33:0] p;
    logic        ready, ready2;
    logic [33:0] result, result2;
    logic        valid, valid2, busy, busy2, err, err2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fios_res_collector #(.s(2), .LATENCY(3), .RES_STRIDE(1)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .res_i(res), .p_i(p),
        .ready_i(ready), .result_o(result), .valid_o(valid), .busy_o(busy), .err_o(err)
    );

    fios_res_collector #(.s(2), .LATENCY(3), .RES_STRIDE(2)) dut2 (
        .clock_i(clk), .reset_i(rst), .start_i(start2), .res_i(res2), .p_i(p),
        .ready_i(ready2), .result_o(result2), .valid_o(valid2), .busy_o(busy2), .err_o(err2)
    );

    typedef struct {
        string       name;
        logic [33:0] p;
        logic [16:0] w0;
        logic [16:0] w1;
        int          hold;
        logic [33:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Start at cycle 0, words at cycles 3 and 4, result checked at cycle 5, ready low for hold cycles.
    task automatic run_vec(input string name, input logic [33:0] pv, input logic [16:0] w0,
                           input logic [16:0] w1, input int hold, input logic [33:0] exp);
        tick; p = pv; start = 1'b1;
        tick; start = 1'b0;
        chk({name, " busy_wait"}, 64'(busy), 64'd1);
        tick;
        tick; res = w0;
        tick; res = w1;
        chk({name, " valid_early"}, 64'(valid), 64'd0);
        tick; res = 17'h1ABCD;
        chk({name, " valid"}, 64'(valid), 64'd1);
        chk({name, " result"}, 64'(result), 64'(exp));
        for (int j = 0; j < hold; j++) begin
            tick;
            chk({name, " valid_held"}, 64'(valid), 64'd1);
            chk({name, " result_held"}, 64'(result), 64'(exp));
        end
        ready = 1'b1;
        tick; ready = 1'b0;
        chk({name, " valid_drop"}, 64'(valid), 64'd0);
        tick;
        chk({name, " busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"subtract",   {17'h00001, 17'h00005}, 17'h00007, 17'h00001, 0, 34'h0_00002};
        vecs[1] = '{"no_sub",     {17'h00001, 17'h00005}, 17'h00003, 17'h00001, 0, 34'h20003};
        vecs[2] = '{"borrow",     {17'h00000, 17'h00005}, 17'h00002, 17'h00001, 1, 34'h1FFFD};
        vecs[3] = '{"equal_bp",   {17'h00001, 17'h00005}, 17'h00005, 17'h00001, 5, 34'h0};
        vecs[4] = '{"equal_max",  {17'h1FFFF, 17'h1FFFF}, 17'h1FFFF, 17'h1FFFF, 0, 34'h0};
        vecs[5] = '{"wide_sub",   {17'h10000, 17'h00000}, 17'h1FFFF, 17'h1FFFF, 2, 34'h1FFFFFFFF};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; res = '0; res2 = '0;
        p = '0; ready = 1'b0; ready2 = 1'b0;
        tick; tick;
        rst = 1'b0;
        chk("reset result", 64'(result), 64'd0);
        chk("reset valid",  64'(valid),  64'd0);
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset err",    64'(err),    64'd0);
        chk("reset valid2", 64'(valid2), 64'd0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i].name, vecs[i].p, vecs[i].w0, vecs[i].w1, vecs[i].hold, vecs[i].exp);

        // Start during COLLECT is ignored with a one-cycle err_o; start during the accepting HOLD cycle too.
        tick; p = {17'h00001, 17'h00005}; start = 1'b1;
        tick; start = 1'b0;
        tick;
        tick; res = 17'h00007; start = 1'b1;
        chk("ign err_before", 64'(err), 64'd0);
        tick; res = 17'h00001; start = 1'b0;
        chk("ign err_pulse", 64'(err), 64'd1);
        tick; res = 17'h0;
        chk("ign err_clear", 64'(err), 64'd0);
        chk("ign valid", 64'(valid), 64'd1);
        chk("ign result", 64'(result), 64'h2);
        ready = 1'b1; start = 1'b1;
        tick; ready = 1'b0; start = 1'b0;
        chk("hold_start err", 64'(err), 64'd1);
        chk("hold_start valid", 64'(valid), 64'd0);
        chk("hold_start busy", 64'(busy), 64'd0);
        tick;
        chk("hold_start err_clear", 64'(err), 64'd0);
        chk("hold_start still_idle", 64'(busy), 64'd0);

        // Stride 2: words at cycles 3 and 5, garbage on cycles 4 and 6 must not be sampled.
        tick; p = {17'h00001, 17'h00005}; start2 = 1'b1;
        tick; start2 = 1'b0;
        tick;
        tick; res2 = 17'h00007;
        tick; res2 = 17'h1FFFF;
        tick; res2 = 17'h00001;
        chk("stride2 valid_early", 64'(valid2), 64'd0);
        tick; res2 = 17'h1FFFF;
        chk("stride2 valid", 64'(valid2), 64'd1);
        chk("stride2 result", 64'(result2), 64'h2);
        ready2 = 1'b1;
        tick; ready2 = 1'b0;
        chk("stride2 valid_drop", 64'(valid2), 64'd0);

        // Reset after word 0 (which leaves borrow=1), then a clean run must see no leftover borrow.
        tick; p = {17'h00001, 17'h00005}; start = 1'b1;
        tick; start = 1'b0;
        tick;
        tick; res = 17'h00003;
        tick; res = 17'h1FFFF; rst = 1'b1;
        tick; rst = 1'b0;
        chk("midrst result", 64'(result), 64'd0);
        chk("midrst valid",  64'(valid),  64'd0);
        chk("midrst busy",   64'(busy),   64'd0);
        chk("midrst err",    64'(err),    64'd0);
        run_vec("after_rst", {17'h00001, 17'h00005}, 17'h00007, 17'h00001, 0, 34'h0_00002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
